exchange_scheduler: RTL and testbench

- Per-frame controller for the board-to-board link. Once per video frame it sends the latest local player record to the SPI transmitter and waits for the opponent record from the SPI receiver.
- It publishes a matched local/opponent pair to the game logic.
- Timeouts, stale-data flagging, and link-up/down status make a missing opponent frame degrade gracefully.
- Sits between the camera/location pipeline, the spi_tx/spi_rx pair, and the game-state logic.

---
 rtl/exchange_scheduler.sv | 174 +++++++++++++++++
 tb/tb_exchange_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exchange_scheduler.sv
// exchange_scheduler: per-frame local/opponent record exchange over SPI.
// Optional EXCHANGE_OVERRUN_COUNT_EN adds overrun_count_out.
module exchange_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 600000,
  parameter int MAX_MISSES = 4,
  localparam int MW = $clog2(MAX_MISSES + 1),
  localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  input  logic [DATA_WIDTH-1:0] local_data_in,
  input  logic                  local_data_valid_in,
  output logic [DATA_WIDTH-1:0] tx_data_out,
  output logic                  tx_trigger_out,
  input  logic                  tx_busy_in,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rx_valid_in,
  output logic [DATA_WIDTH-1:0] local_data_out,
  output logic [DATA_WIDTH-1:0] opponent_data_out,
  output logic                  exchange_valid_out,
  output logic                  opponent_stale_out,
  output logic                  link_up_out,
`ifdef EXCHANGE_OVERRUN_COUNT_EN
  output logic [7:0]            overrun_count_out,
`endif
  output logic [MW-1:0]         miss_count_out
);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_TX, WAIT_RX, PUBLISH
  } state_t;

  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] held_q, held_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] local_data_q, local_data_d;
  logic [DATA_WIDTH-1:0] opp_data_q, opp_data_d;
  logic                  rx_pending_q, rx_pending_d;
  logic                  tx_first_q, tx_first_d;
  logic                  stale_q, stale_d;
  logic [MW-1:0]         miss_count_q, miss_count_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  timeout;
  logic                  go_pub;
  logic                  got_rx;

  // Limit is hit when the count is about to become TIMEOUT_CYCLES-1.
  assign timeout = (tmo_q + TW'(1)) == TW'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d        = state_q;
    held_d         = local_data_valid_in ? local_data_in : held_q;
    rx_data_d      = rx_valid_in ? rx_data_in : rx_data_q;
    rx_pending_d   = rx_pending_q | rx_valid_in;
    tx_data_d      = tx_data_q;
    local_data_d   = local_data_q;
    opp_data_d     = opp_data_q;
    stale_d        = stale_q;
    miss_count_d   = miss_count_q;
    tmo_d          = tmo_q;
    tx_first_d     = 1'b0;
    tx_trigger_out = 1'b0;
    go_pub         = 1'b0;
    got_rx         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          state_d   = SEND;
          tx_data_d = held_d;
          tmo_d     = '0;
        end
      end
      SEND: begin
        tmo_d = tmo_q + TW'(1);
        if (timeout) begin
          go_pub = 1'b1;
        end else if (!tx_busy_in) begin
          tx_trigger_out = 1'b1;
          tx_first_d     = 1'b1;
          state_d        = WAIT_TX;
        end
      end
      WAIT_TX: begin
        tmo_d = tmo_q + TW'(1);
        if (timeout) begin
          go_pub = 1'b1;
        end else if (!tx_first_q && !tx_busy_in) begin
          state_d = WAIT_RX;
        end
      end
      WAIT_RX: begin
        tmo_d = tmo_q + TW'(1);
        if (rx_pending_q || rx_valid_in) begin
          go_pub = 1'b1;
          got_rx = 1'b1;
        end else if (timeout) begin
          go_pub = 1'b1;
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_pub) begin
      state_d      = PUBLISH;
      local_data_d = tx_data_q;
      stale_d      = !got_rx;
      if (got_rx) begin
        opp_data_d   = rx_data_d;
        miss_count_d = '0;
        rx_pending_d = 1'b0;
      end else if (miss_count_q < MW'(MAX_MISSES)) begin
        miss_count_d = miss_count_q + MW'(1);
      end
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      held_q       <= '0;
      rx_data_q    <= '0;
      rx_pending_q <= 1'b0;
      tx_data_q    <= '0;
      local_data_q <= '0;
      opp_data_q   <= '0;
      stale_q      <= 1'b0;
      miss_count_q <= MW'(MAX_MISSES);
      tmo_q        <= '0;
      tx_first_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      rx_data_q    <= rx_data_d;
      rx_pending_q <= rx_pending_d;
      tx_data_q    <= tx_data_d;
      local_data_q <= local_data_d;
      opp_data_q   <= opp_data_d;
      stale_q      <= stale_d;
      miss_count_q <= miss_count_d;
      tmo_q        <= tmo_d;
      tx_first_q   <= tx_first_d;
    end
  end

`ifdef EXCHANGE_OVERRUN_COUNT_EN
  logic [7:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (frame_start_in && state_q != IDLE && overrun_q != 8'hFF) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) overrun_q <= '0;
    else        overrun_q <= overrun_d;
  end

  assign overrun_count_out = overrun_q;
`endif

  assign tx_data_out        = tx_data_q;
  assign local_data_out     = local_data_q;
  assign opponent_data_out  = opp_data_q;
  assign exchange_valid_out = (state_q == PUBLISH);
  assign opponent_stale_out = stale_q;
  assign miss_count_out     = miss_count_q;
  assign link_up_out        = miss_count_q < MW'(MAX_MISSES);

endmodule

// File: tb/tb_exchange_scheduler.sv
// tb_exchange_scheduler: frame table plus scoreboarded trigger/publish checks.
// Hand-written sequences cover collisions and mid-exchange reset.
module tb_exchange_scheduler;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        frame_start_in = 1'b0;
  logic [31:0] local_data_in = '0;
  logic        local_data_valid_in = 1'b0;
  logic [31:0] tx_data_out;
  logic        tx_trigger_out;
  logic        tx_busy_in = 1'b0;
  logic [31:0] rx_data_in = '0;
  logic        rx_valid_in = 1'b0;
  logic [31:0] local_data_out;
  logic [31:0] opponent_data_out;
  logic        exchange_valid_out;
  logic        opponent_stale_out;
  logic        link_up_out;
  logic [2:0]  miss_count_out;
`ifdef EXCHANGE_OVERRUN_COUNT_EN
  logic [7:0]  overrun_count_out;
`endif

  exchange_scheduler #(
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(100),
    .MAX_MISSES(4)
  ) dut (
`ifdef EXCHANGE_OVERRUN_COUNT_EN
    .overrun_count_out(overrun_count_out),
`endif
    .clk_pixel_in(clk),
    .rst_in(rst_in),
    .frame_start_in(frame_start_in),
    .local_data_in(local_data_in),
    .local_data_valid_in(local_data_valid_in),
    .tx_data_out(tx_data_out),
    .tx_trigger_out(tx_trigger_out),
    .tx_busy_in(tx_busy_in),
    .rx_data_in(rx_data_in),
    .rx_valid_in(rx_valid_in),
    .local_data_out(local_data_out),
    .opponent_data_out(opponent_data_out),
    .exchange_valid_out(exchange_valid_out),
    .opponent_stale_out(opponent_stale_out),
    .link_up_out(link_up_out),
    .miss_count_out(miss_count_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } trig_t;

  typedef struct {
    int          cyc;
    logic [31:0] loc;
    logic [31:0] opp;
    logic        stale;
    int          miss;
    logic        link;
  } pub_t;

  trig_t trig_q[$];
  pub_t  pub_q[$];

  // rx_mode: 0 none, 1 pulse in IDLE before frame_start, 2 pulse at rx_off
  typedef struct {
    logic [31:0] early;
    logic        fs_en;
    logic [31:0] fs_val;
    int          pre;
    int          shift;
    int          rx_mode;
    int          rx_off;
    logic [31:0] rx_data;
    int          trig;
    int          pub;
    logic [31:0] opp;
    logic        stale;
    int          miss;
    logic        link;
  } frame_t;

  frame_t tbl[10];

  always @(negedge clk) begin
    if (!rst_in) begin
      if (tx_trigger_out) begin
        if (trig_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_trigger: got trigger at cycle %0d, none due",
                   cyc);
        end else begin
          trig_t t;
          t = trig_q.pop_front();
          chk("trig_cycle", 64'(cyc), 64'(t.cyc));
          chk("tx_data", 64'(tx_data_out), 64'(t.data));
        end
      end
      if (exchange_valid_out) begin
        if (pub_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_publish: got publish at cycle %0d, none due",
                   cyc);
        end else begin
          pub_t p;
          p = pub_q.pop_front();
          chk("pub_cycle", 64'(cyc), 64'(p.cyc));
          chk("local_out", 64'(local_data_out), 64'(p.loc));
          chk("tx_data_held", 64'(tx_data_out), 64'(p.loc));
          chk("opponent", 64'(opponent_data_out), 64'(p.opp));
          chk("stale", 64'(opponent_stale_out), 64'(p.stale));
          chk("miss_count", 64'(miss_count_out), 64'(p.miss));
          chk("link_up", 64'(link_up_out), 64'(p.link));
        end
      end
    end
  end

  task automatic step(input logic fs, input logic lv, input logic [31:0] ld,
                      input logic rv, input logic [31:0] rd, input logic bz);
    @(posedge clk);
    #1;
    frame_start_in      = fs;
    local_data_valid_in = lv;
    local_data_in       = ld;
    rx_valid_in         = rv;
    rx_data_in          = rd;
    tx_busy_in          = bz;
  endtask

  task automatic run_frame(input frame_t f);
    logic        lv, rv, bz;
    logic [31:0] ld;
    logic [31:0] exp_tx;
    exp_tx = f.fs_en ? f.fs_val : f.early;
    for (int k = -3; k <= f.pub + 1; k++) begin
      lv = 1'b0;
      ld = '0;
      if (k == -3) begin lv = 1'b1; ld = f.early; end
      if (k == 0 && f.fs_en) begin lv = 1'b1; ld = f.fs_val; end
      if (k == 3) begin lv = 1'b1; ld = 32'hDEAD_0000 ^ f.early; end
      rv = (f.rx_mode == 1 && k == -2) || (f.rx_mode == 2 && k == f.rx_off);
      bz = (k >= 0 && k < f.pre) || (k > f.trig && k <= f.trig + f.shift);
      step(k == 0, lv, ld, rv, f.rx_data, bz);
      if (k == 0) begin
        trig_q.push_back('{cyc + f.trig, exp_tx});
        pub_q.push_back('{cyc + f.pub, exp_tx, f.opp, f.stale, f.miss, f.link});
      end
    end
  endtask

  initial begin
    tbl[0] = '{32'hA5A5_0001, 1'b0, 32'h0, 0, 10, 2, 20, 32'h1234_5678,
               1, 21, 32'h1234_5678, 1'b0, 0, 1'b1};
    tbl[1] = '{32'h0000_1111, 1'b1, 32'h0000_2222, 0, 5, 1, 0, 32'h0000_BEEF,
               1, 9, 32'h0000_BEEF, 1'b0, 0, 1'b1};
    tbl[2] = '{32'h0000_3002, 1'b0, 32'h0, 0, 4, 0, 0, 32'h0,
               1, 100, 32'h0000_BEEF, 1'b1, 1, 1'b1};
    tbl[3] = '{32'h0000_3003, 1'b0, 32'h0, 0, 4, 0, 0, 32'h0,
               1, 100, 32'h0000_BEEF, 1'b1, 2, 1'b1};
    tbl[4] = '{32'h0000_3004, 1'b0, 32'h0, 0, 4, 0, 0, 32'h0,
               1, 100, 32'h0000_BEEF, 1'b1, 3, 1'b1};
    tbl[5] = '{32'h0000_3005, 1'b0, 32'h0, 0, 4, 0, 0, 32'h0,
               1, 100, 32'h0000_BEEF, 1'b1, 4, 1'b0};
    tbl[6] = '{32'h0000_4000, 1'b0, 32'h0, 0, 4, 2, 30, 32'hCAFE_0006,
               1, 31, 32'hCAFE_0006, 1'b0, 0, 1'b1};
    tbl[7] = '{32'h0000_5000, 1'b1, 32'h0000_5001, 7, 3, 2, 25, 32'hCAFE_0007,
               7, 26, 32'hCAFE_0007, 1'b0, 0, 1'b1};
    tbl[8] = '{32'h0000_6000, 1'b0, 32'h0, 0, 2, 0, 0, 32'h0,
               1, 100, 32'hCAFE_0007, 1'b1, 1, 1'b1};
    tbl[9] = '{32'h0000_7000, 1'b0, 32'h0, 0, 2, 2, 99, 32'hCAFE_0009,
               1, 100, 32'hCAFE_0009, 1'b0, 0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst_in = 1'b0;
    @(negedge clk);
    chk("rst_tx_data", 64'(tx_data_out), 64'h0);
    chk("rst_trigger", 64'(tx_trigger_out), 64'h0);
    chk("rst_valid", 64'(exchange_valid_out), 64'h0);
    chk("rst_local", 64'(local_data_out), 64'h0);
    chk("rst_opp", 64'(opponent_data_out), 64'h0);
    chk("rst_stale", 64'(opponent_stale_out), 64'h0);
    chk("rst_miss", 64'(miss_count_out), 64'd4);
    chk("rst_link", 64'(link_up_out), 64'h0);

    foreach (tbl[i]) run_frame(tbl[i]);

    // Extra frame_start in WAIT_RX is ignored; rx during PUBLISH carries over.
    for (int k = -3; k <= 21; k++) begin
      step(k == 0 || k == 10, k == -3, 32'h0000_8000,
           k == 20 || k == 21, (k == 21) ? 32'hCAFE_000B : 32'hCAFE_000A,
           1'b0);
      if (k == 0) begin
        trig_q.push_back('{cyc + 1, 32'h0000_8000});
        pub_q.push_back('{cyc + 21, 32'h0000_8000, 32'hCAFE_000A, 1'b0, 0, 1'b1});
      end
    end
    for (int k = 0; k <= 6; k++) begin
      step(k == 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      if (k == 0) begin
        trig_q.push_back('{cyc + 1, 32'h0000_8000});
        pub_q.push_back('{cyc + 5, 32'h0000_8000, 32'hCAFE_000B, 1'b0, 0, 1'b1});
      end
    end
`ifdef EXCHANGE_OVERRUN_COUNT_EN
    @(negedge clk);
    chk("overrun_count", 64'(overrun_count_out), 64'd1);
`endif

    // Reset while waiting for the opponent record.
    for (int k = -3; k <= 10; k++) begin
      step(k == 0, k == -3, 32'h0000_9000, 1'b0, 32'h0, 1'b0);
      if (k == 0) trig_q.push_back('{cyc + 1, 32'h0000_9000});
    end
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_data", 64'(tx_data_out), 64'h0);
    chk("mid_rst_trigger", 64'(tx_trigger_out), 64'h0);
    chk("mid_rst_valid", 64'(exchange_valid_out), 64'h0);
    chk("mid_rst_local", 64'(local_data_out), 64'h0);
    chk("mid_rst_opp", 64'(opponent_data_out), 64'h0);
    chk("mid_rst_stale", 64'(opponent_stale_out), 64'h0);
    chk("mid_rst_miss", 64'(miss_count_out), 64'd4);
    chk("mid_rst_link", 64'(link_up_out), 64'h0);
`ifdef EXCHANGE_OVERRUN_COUNT_EN
    chk("mid_rst_overrun", 64'(overrun_count_out), 64'd0);
`endif
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Miss count saturates at MAX_MISSES after reset.
    for (int k = -3; k <= 101; k++) begin
      step(k == 0, k == -3, 32'h0000_9100, 1'b0, 32'h0, 1'b0);
      if (k == 0) begin
        trig_q.push_back('{cyc + 1, 32'h0000_9100});
        pub_q.push_back('{cyc + 100, 32'h0000_9100, 32'h0, 1'b1, 4, 1'b0});
      end
    end

    @(negedge clk);
    chk("trig_outstanding", 64'(trig_q.size()), 64'd0);
    chk("pub_outstanding", 64'(pub_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
